// File: rtl/id_stage.sv
// Instruction-decode stage of the single-cycle RV32I core: main control decode, sign-extended immediate, 32x32 register file.
// Optional ID_WB_BYPASS_EN: forwards WB_out to dataA/dataB when the source matches the register being written this cycle.
module id_stage #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [31:0]     instruction,
  input  logic [XLEN-1:0] WB_out,
  output logic            RegWrite,
  output logic            ALUSrc,
  output logic            MemWrite,
  output logic            MemRead,
  output logic            ResultSrc,
  output logic            Branch,
  output logic [1:0]      ALUOp,
  output logic [XLEN-1:0] dataA,
  output logic [XLEN-1:0] dataB,
  output logic [XLEN-1:0] dataD,
  output logic [XLEN-1:0] imm_ext,
  output logic [4:0]      rd,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I_ALU  = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  logic [6:0]      opcode;
  logic            sign;
  logic [XLEN-1:0] regs [NREGS];
  logic            wr_en;

  assign opcode = instruction[6:0];
  assign sign   = instruction[31];
  assign rd     = instruction[11:7];
  assign rs1    = instruction[19:15];
  assign rs2    = instruction[24:20];

  always_comb begin
    RegWrite  = 1'b0;
    ALUSrc    = 1'b0;
    MemWrite  = 1'b0;
    MemRead   = 1'b0;
    ResultSrc = 1'b0;
    Branch    = 1'b0;
    ALUOp     = 2'b00;
    case (opcode)
      OP_R: begin
        RegWrite = 1'b1;
        ALUOp    = 2'b10;
      end
      OP_I_ALU: begin
        RegWrite = 1'b1;
        ALUSrc   = 1'b1;
        ALUOp    = 2'b10;
      end
      OP_LOAD: begin
        RegWrite  = 1'b1;
        ALUSrc    = 1'b1;
        MemRead   = 1'b1;
        ResultSrc = 1'b1;
      end
      OP_STORE: begin
        ALUSrc   = 1'b1;
        MemWrite = 1'b1;
      end
      OP_BRANCH: begin
        Branch = 1'b1;
        ALUOp  = 2'b01;
      end
      OP_LUI, OP_AUIPC, OP_JAL, OP_JALR: begin
        RegWrite = 1'b1;
        ALUSrc   = 1'b1;
      end
      default: ;
    endcase
  end

  // Immediate format follows the opcode; R-type and unknown opcodes carry no immediate.
  always_comb begin
    imm_ext = '0;
    case (opcode)
      OP_I_ALU, OP_LOAD, OP_JALR:
        imm_ext = {{20{sign}}, instruction[31:20]};
      OP_STORE:
        imm_ext = {{20{sign}}, instruction[31:25], instruction[11:7]};
      OP_BRANCH:
        imm_ext = {{19{sign}}, sign, instruction[7], instruction[30:25], instruction[11:8], 1'b0};
      OP_LUI, OP_AUIPC:
        imm_ext = {instruction[31:12], 12'b0};
      OP_JAL:
        imm_ext = {{11{sign}}, sign, instruction[19:12], instruction[20], instruction[30:21], 1'b0};
      default: imm_ext = '0;
    endcase
  end

  assign wr_en = RegWrite && (rd != 5'd0) && !rst;

  // Reset takes priority over a coincident writeback.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (wr_en) begin
      regs[rd] <= WB_out;
    end
  end

  always_comb begin
    dataA = (rs1 == 5'd0) ? '0 : regs[rs1];
    dataB = (rs2 == 5'd0) ? '0 : regs[rs2];
    dataD = (rd  == 5'd0) ? '0 : regs[rd];
`ifdef ID_WB_BYPASS_EN
    if (wr_en && (rs1 == rd)) dataA = WB_out;
    if (wr_en && (rs2 == rd)) dataB = WB_out;
`endif
  end

endmodule

// File: tb/tb_id_stage.sv
// Self-checking bench for id_stage: directed cases plus randomized instructions against a behavioural model.
module tb_id_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instruction, WB_out;
  logic        RegWrite, ALUSrc, MemWrite, MemRead, ResultSrc, Branch;
  logic [1:0]  ALUOp;
  logic [31:0] dataA, dataB, dataD, imm_ext;
  logic [4:0]  rd, rs1, rs2;

  int errors = 0;
  int checks = 0;
  int txn    = 0;
  logic [31:0] model_regs [32];

  id_stage dut (
    .clk(clk), .rst(rst), .instruction(instruction), .WB_out(WB_out),
    .RegWrite(RegWrite), .ALUSrc(ALUSrc), .MemWrite(MemWrite), .MemRead(MemRead),
    .ResultSrc(ResultSrc), .Branch(Branch), .ALUOp(ALUOp),
    .dataA(dataA), .dataB(dataB), .dataD(dataD), .imm_ext(imm_ext),
    .rd(rd), .rs1(rs1), .rs2(rs2)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h (txn %0d)", tag, obs, exp, txn);
    end
  endtask

  // {RegWrite, ALUSrc, MemWrite, MemRead, ResultSrc, Branch, ALUOp}
  function automatic logic [7:0] ref_ctrl(input logic [31:0] ins);
    case (ins[6:0])
      7'b0110011: return 8'b1000_0010;
      7'b0010011: return 8'b1100_0010;
      7'b0000011: return 8'b1101_1000;
      7'b0100011: return 8'b0110_0000;
      7'b1100011: return 8'b0000_0101;
      7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111: return 8'b1100_0000;
      default:    return 8'b0000_0000;
    endcase
  endfunction

  function automatic logic [31:0] ref_imm(input logic [31:0] ins);
    logic [31:0] s31, s20, s25;
    s31 = $unsigned($signed(ins) >>> 31);
    s20 = $unsigned($signed(ins) >>> 20);
    s25 = $unsigned($signed(ins) >>> 25);
    case (ins[6:0])
      7'b0010011, 7'b0000011, 7'b1100111: return s20;
      7'b0100011: return (s25 << 5) | 32'(ins[11:7]);
      7'b1100011: return (s31 << 12) | (32'(ins[7]) << 11) | (32'(ins[30:25]) << 5) | (32'(ins[11:8]) << 1);
      7'b0110111, 7'b0010111: return ins & 32'hFFFF_F000;
      7'b1101111: return (s31 << 20) | (32'(ins[19:12]) << 12) | (32'(ins[20]) << 11) | (32'(ins[30:21]) << 1);
      default:    return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] ref_read(input logic [4:0] idx);
    return (idx == 5'd0) ? 32'h0 : model_regs[idx];
  endfunction

  // Drive one instruction for a full clock, check all outputs mid-cycle, then advance the model.
  task automatic cycle(input logic [31:0] ins, input logic [31:0] wb, input logic r);
    logic [7:0]  ctrl;
    logic [4:0]  f_rd, f_rs1, f_rs2;
    logic [31:0] exp_a, exp_b;
    logic        writes;
    @(negedge clk);
    instruction = ins;
    WB_out      = wb;
    rst         = r;
    txn++;
    $display("txn %0d instr=%08h wb=%08h rst=%0b", txn, ins, wb, r);
    ctrl  = ref_ctrl(ins);
    f_rd  = ins[11:7];
    f_rs1 = ins[19:15];
    f_rs2 = ins[24:20];
    writes = ctrl[7] && (f_rd != 5'd0) && !r;
    exp_a = ref_read(f_rs1);
    exp_b = ref_read(f_rs2);
`ifdef ID_WB_BYPASS_EN
    if (writes && f_rs1 == f_rd) exp_a = wb;
    if (writes && f_rs2 == f_rd) exp_b = wb;
`endif
    #2;
    check("ctrl", {24'h0, RegWrite, ALUSrc, MemWrite, MemRead, ResultSrc, Branch, ALUOp}, {24'h0, ctrl});
    check("imm", imm_ext, ref_imm(ins));
    check("fields", {17'h0, rd, rs1, rs2}, {17'h0, f_rd, f_rs1, f_rs2});
    check("dataA", dataA, exp_a);
    check("dataB", dataB, exp_b);
    check("dataD", dataD, ref_read(f_rd));
    @(posedge clk);
    if (r) begin
      for (int i = 0; i < 32; i++) model_regs[i] = 32'h0;
    end else if (writes) begin
      model_regs[f_rd] = wb;
    end
    #1;
  endtask

  localparam logic [6:0] OPS [10] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
                                      7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b0000000};

  initial begin
    logic [31:0] ins;
    rst = 1'b1;
    instruction = 32'h0;
    WB_out = 32'h0;
    repeat (2) @(posedge clk);
    for (int i = 0; i < 32; i++) model_regs[i] = 32'h0;
    #1;

    // Every index reads zero after reset.
    for (int i = 0; i < 32; i++) begin
      ins = {7'b0, 5'(i), 5'(i), 3'b0, 5'(i), 7'b0};
      cycle(ins, 32'hDEAD_BEEF, 1'b0);
      check("rst_read", dataA, 32'h0);
    end

    cycle(32'h00c58633, 32'h0, 1'b1);
    cycle(32'h00c58633, 32'h0, 1'b0);
    check("add_rs1", {27'h0, rs1}, 32'h0B);
    check("add_ctrl", {29'h0, RegWrite, ALUOp}, 32'h6);
    cycle(32'h00c58593, 32'h0, 1'b1);
    check("addi_imm", imm_ext, 32'h0000000C);
    cycle(32'h0045a603, 32'h0, 1'b1);
    check("lw_imm", imm_ext, 32'h4);
    cycle(32'h00c5a223, 32'h0, 1'b1);
    check("sw_imm", imm_ext, 32'h4);
    cycle(32'h00c58663, 32'h0, 1'b1);
    check("beq_imm", imm_ext, 32'h0000000C);
    cycle(32'hFFF58593, 32'h0, 1'b1);
    check("neg_imm", imm_ext, 32'hFFFFFFFF);

    cycle(32'h00c58593, 32'h1234ABCD, 1'b0);
    cycle(32'h00b58663, 32'h0, 1'b0);
    check("x11_wr", dataA, 32'h1234ABCD);
    cycle(32'h00100013, 32'hFFFFFFFF, 1'b0);
    cycle(32'h00100093, 32'h5555_5555, 1'b0);
    check("x0_wr", dataA, 32'h0);
    cycle(32'h00c58593, 32'h7777_0000, 1'b1);
    cycle(32'h00b58663, 32'h0, 1'b0);
    check("rst_x11", dataA, 32'h0);

    // Random traffic; register fields often drawn from a small pool to force hazards.
    for (int n = 0; n < 400; n++) begin
      ins = $urandom;
      if ($urandom_range(0, 9) != 0) ins[6:0] = OPS[$urandom_range(0, 9)];
      if ($urandom_range(0, 1) == 1) begin
        ins[11:7]  = 5'($urandom_range(0, 3));
        ins[19:15] = 5'($urandom_range(0, 3));
        ins[24:20] = 5'($urandom_range(0, 3));
      end
      cycle(ins, $urandom, ($urandom_range(0, 39) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
